yapay_zeka_carpim_toplayici: RTL and testbench

//  Multiply-accumulate back end of the AI accelerator; sits directly downstream of the operand register files.
//  - Each cycle the X-extension RUN is active (carpma_rst_i=0), takes one packed word from the data file and one from the coefficient file.
//  - Multiplies corresponding signed lanes, sums the lane products and accumulates them into a 32-bit result.
//  - The result feeds the writeback of the RUN instruction.

---
 rtl/yapay_zeka_carpim_toplayici.sv | 121 ++++++++++++
 tb/tb_yapay_zeka_carpim_toplayici.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/yapay_zeka_carpim_toplayici.sv
// yapay_zeka_carpim_toplayici
// Two-stage multiply-accumulate back end of the AI accelerator.
//   Stage 1 multiplies corresponding signed lanes of the data and
//   coefficient words. Stage 2 sums the lane products and accumulates
//   them into a SONUC_BIT-wide result.
//
// Ports:
//   clk_i           clock, all state updates on posedge
//   rst_ni          synchronous reset, active-low
//   ddb_durdur_i    pipeline stall, freezes every register
//   carpma_rst_i    1 = idle/hold, 0 = operands valid this cycle
//   carp_deger1_i   packed data operand
//   carp_deger2_i   packed coefficient operand
//   sonuc_o         accumulator value
//   sonuc_gecerli_o completed run held in sonuc_o, pipeline empty
//
// Configuration macro:
//   YZH_DOYURMALI_TOPLAMA_EN  saturating stage-2 add instead of wrapping

module yapay_zeka_carpim_toplayici #(
    parameter int unsigned SERIT_BIT = 8,
    parameter int unsigned SONUC_BIT = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ddb_durdur_i,
    input  logic                 carpma_rst_i,
    input  logic [31:0]          carp_deger1_i,
    input  logic [31:0]          carp_deger2_i,
    output logic [SONUC_BIT-1:0] sonuc_o,
    output logic                 sonuc_gecerli_o
);

    localparam int SERIT_SAYISI = 32 / SERIT_BIT;
    localparam int CARPIM_BIT   = 2 * SERIT_BIT;

    logic                         onceki_bos;
    logic                         s1_v;
    logic                         s1_ilk;
    logic                         gecerli;
    logic signed [CARPIM_BIT-1:0] s1_carpim [SERIT_SAYISI];
    logic signed [CARPIM_BIT-1:0] carpim    [SERIT_SAYISI];
    logic signed [SONUC_BIT-1:0]  acc;
    logic signed [SONUC_BIT-1:0]  toplam;
    logic signed [SONUC_BIT-1:0]  acc_yeni;
    logic                         etkin;
    logic                         ilk;

    assign etkin = ~carpma_rst_i & ~ddb_durdur_i;
    // A run starts on the first accepted operand after an idle cycle.
    assign ilk   = etkin & onceki_bos;

    // Lane products; operands sign-extended to product width first.
    always_comb begin
        for (int k = 0; k < SERIT_SAYISI; k++) begin
            carpim[k] = CARPIM_BIT'($signed(carp_deger1_i[k*SERIT_BIT +: SERIT_BIT]))
                      * CARPIM_BIT'($signed(carp_deger2_i[k*SERIT_BIT +: SERIT_BIT]));
        end
    end

    always_comb begin
        toplam = '0;
        for (int k = 0; k < SERIT_SAYISI; k++) begin
            toplam = toplam + SONUC_BIT'(s1_carpim[k]);
        end
    end

`ifdef YZH_DOYURMALI_TOPLAMA_EN
    logic signed [SONUC_BIT-1:0] toplam_ham;

    // Overflow only when both addends share a sign that the sum lost.
    always_comb begin
        toplam_ham = acc + toplam;
        acc_yeni   = toplam_ham;
        if ((acc[SONUC_BIT-1] == toplam[SONUC_BIT-1]) &&
            (toplam_ham[SONUC_BIT-1] != acc[SONUC_BIT-1])) begin
            acc_yeni = acc[SONUC_BIT-1] ? {1'b1, {(SONUC_BIT-1){1'b0}}}
                                        : {1'b0, {(SONUC_BIT-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_yeni = acc + toplam;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            onceki_bos <= 1'b1;
            s1_v       <= 1'b0;
            s1_ilk     <= 1'b0;
            acc        <= '0;
            gecerli    <= 1'b0;
            for (int k = 0; k < SERIT_SAYISI; k++) begin
                s1_carpim[k] <= '0;
            end
        end else if (!ddb_durdur_i) begin
            onceki_bos <= carpma_rst_i;
            s1_v       <= etkin;
            if (etkin) begin
                s1_ilk <= ilk;
                for (int k = 0; k < SERIT_SAYISI; k++) begin
                    s1_carpim[k] <= carpim[k];
                end
            end
            if (s1_v) begin
                acc <= s1_ilk ? toplam : acc_yeni;
            end
            // Drained: stage 2 consumes the last product, stage 1 gets nothing.
            if (ilk) begin
                gecerli <= 1'b0;
            end else if (s1_v && !etkin) begin
                gecerli <= 1'b1;
            end
        end
    end

    assign sonuc_o         = acc;
    assign sonuc_gecerli_o = gecerli;

endmodule

// File: tb/tb_yapay_zeka_carpim_toplayici.sv
module tb_yapay_zeka_carpim_toplayici;

    logic        clk;
    logic        rst_n;
    logic        durdur;
    logic        carpma_rst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sonuc;
    logic        gecerli;

    int n_cmp  = 0;
    int n_fail = 0;

    yapay_zeka_carpim_toplayici dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ddb_durdur_i    (durdur),
        .carpma_rst_i    (carpma_rst),
        .carp_deger1_i   (d1),
        .carp_deger2_i   (d2),
        .sonuc_o         (sonuc),
        .sonuc_gecerli_o (gecerli)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [31:0] D1_10 = 32'h0102_0304;
    localparam logic [31:0] D2_10 = 32'h0101_0101;

    initial begin
        // T1 reset with random inputs
        rst_n      = 1'b0;
        durdur     = 1'($urandom);
        carpma_rst = 1'($urandom);
        d1         = $urandom;
        d2         = $urandom;
        step();
        step();
        chk("t1_rst_sonuc", sonuc, 32'd0);
        chk("t1_rst_gecerli", {31'd0, gecerli}, 32'd0);
        rst_n      = 1'b1;
        durdur     = 1'b0;
        carpma_rst = 1'b1;
        step();
        step();
        chk("t1_idle_sonuc", sonuc, 32'd0);
        chk("t1_idle_gecerli", {31'd0, gecerli}, 32'd0);

        // T2 17-cycle run, 10 per cycle
        d1         = D1_10;
        d2         = D2_10;
        carpma_rst = 1'b0;
        step();
        step();
        chk("t2_first_sum", sonuc, 32'd10);
        for (int i = 2; i < 17; i++) step();
        chk("t2_last_op_sonuc", sonuc, 32'd160);
        chk("t2_last_op_gecerli", {31'd0, gecerli}, 32'd0);
        carpma_rst = 1'b1;
        step();
        chk("t2_done_sonuc", sonuc, 32'd170);
        chk("t2_done_gecerli", {31'd0, gecerli}, 32'd1);
        step();
        chk("t2_hold_sonuc", sonuc, 32'd170);

        // T3 signed lanes, single-cycle run
        d1         = 32'hFF80_007F;
        d2         = 32'h7F7F_0202;
        carpma_rst = 1'b0;
        step();
        chk("t3_start_gecerli", {31'd0, gecerli}, 32'd0);
        carpma_rst = 1'b1;
        step();
        chk("t3_sonuc", sonuc, 32'hFFFF_C0FF);
        chk("t3_gecerli", {31'd0, gecerli}, 32'd1);

        // T4 stall mid-run; idle request during stall must be ignored
        d1         = D1_10;
        d2         = D2_10;
        carpma_rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t4_pre_stall", sonuc, 32'd70);
        durdur     = 1'b1;
        carpma_rst = 1'b1;
        d1         = $urandom;
        d2         = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_sonuc", sonuc, 32'd70);
            chk("t4_stall_gecerli", {31'd0, gecerli}, 32'd0);
        end
        durdur     = 1'b0;
        carpma_rst = 1'b0;
        d1         = D1_10;
        d2         = D2_10;
        for (int i = 0; i < 9; i++) step();
        chk("t4_last_op", sonuc, 32'd160);
        carpma_rst = 1'b1;
        step();
        chk("t4_sonuc", sonuc, 32'd170);
        chk("t4_gecerli", {31'd0, gecerli}, 32'd1);

        // T5 back-to-back runs: A (3 x 10), one idle cycle, B (2 x 5)
        carpma_rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        carpma_rst = 1'b1;
        step();
        chk("t5_a_sonuc", sonuc, 32'd30);
        chk("t5_a_gecerli", {31'd0, gecerli}, 32'd1);
        d1         = 32'h0101_0101;
        d2         = 32'h0101_0201;
        carpma_rst = 1'b0;
        step();
        chk("t5_b_start_sonuc", sonuc, 32'd30);
        chk("t5_b_start_gecerli", {31'd0, gecerli}, 32'd0);
        step();
        chk("t5_b_first", sonuc, 32'd5);
        carpma_rst = 1'b1;
        step();
        chk("t5_b_sonuc", sonuc, 32'd10);
        chk("t5_b_gecerli", {31'd0, gecerli}, 32'd1);

        // T6 overflow: 64516 per cycle; 33286 sums = 0x7FFFF018, one more overflows
        d1         = 32'h7F7F_7F7F;
        d2         = 32'h7F7F_7F7F;
        carpma_rst = 1'b0;
        for (int i = 0; i < 33287; i++) step();
        chk("t6_near_max", sonuc, 32'h7FFF_F018);
        carpma_rst = 1'b1;
        step();
`ifdef YZH_DOYURMALI_TOPLAMA_EN
        chk("t6_overflow", sonuc, 32'h7FFF_FFFF);
`else
        chk("t6_overflow", sonuc, 32'h8000_EC1C);
`endif
        chk("t6_gecerli", {31'd0, gecerli}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
